kan_layer_kernel: RTL and testbench

- Compute kernel for one KAN layer, sitting between the read and write kernel ports of the inter-layer ping-pong buffer.
- Pops input activations x_i one at a time from the buffer read port.
- For every output neuron j, evaluates a piecewise-linear edge function phi_ij(x_i) using coefficients from an external coefficient RAM, and accumulates it into acc[j].
- After the last input, pushes OUT_DIM saturated results into the buffer write port.

---
 rtl/kan_pkg.sv | 55 +++++
 rtl/kan_pwl_eval.sv | 27 ++
 rtl/kan_layer_kernel.sv | 160 ++++++++++++++++
 tb/tb_kan_layer_kernel.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kan_pkg.sv
// Shared types and helpers for the KAN layer kernel.
// Datapath sizing lives here so the kernel and its evaluator agree on widths.
package kan_pkg;

  localparam int DWIDTH   = 16;  // activation width, signed fixed point
  localparam int FRAC     = 8;   // fractional bits of activations and coefficients
  localparam int SEG_BITS = 3;   // log2 of linear segments per edge function
  localparam int MAX_IN   = 64;
  localparam int MAX_OUT  = 64;
  localparam int ACC_W    = 32;

  localparam int IN_W   = $clog2(MAX_IN) + 1;
  localparam int OUT_W  = $clog2(MAX_OUT) + 1;
  localparam int JW     = $clog2(MAX_OUT);
  localparam int ADDR_W = $clog2(MAX_IN * MAX_OUT) + SEG_BITS;
  localparam int RW     = ADDR_W - SEG_BITS;  // edge index part of the address
  localparam int T_W    = DWIDTH - SEG_BITS;  // in-segment offset width

  // Accumulator and result share the same FRAC scaling, so no rescale on output.
  localparam int OUT_SHIFT = FRAC - FRAC;

  // Coefficient word layout: {base, slope}
  localparam int COEF_SLOPE_LSB = 0;
  localparam int COEF_BASE_LSB  = DWIDTH;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DWIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EVAL, S_DRAIN, S_WRITE, S_DONE
  } state_e;

  typedef struct packed {
    logic [SEG_BITS-1:0] seg;
    logic [T_W-1:0]      t;
  } xsplit_t;

  // Map signed x onto segment 0..2^SEG_BITS-1 (flipped MSB) plus unsigned offset.
  function automatic xsplit_t split_x(input logic [DWIDTH-1:0] x);
    xsplit_t r;
    r.seg = {~x[DWIDTH-1], x[DWIDTH-2 -: SEG_BITS-1]};
    r.t   = x[T_W-1:0];
    return r;
  endfunction

  // Clamp an accumulator value to the signed DWIDTH range.
  function automatic logic [DWIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic [DWIDTH-1:0] r;
    if (a > SAT_MAX)      r = {1'b0, {(DWIDTH-1){1'b1}}};
    else if (a < SAT_MIN) r = {1'b1, {(DWIDTH-1){1'b0}}};
    else                  r = a[DWIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/kan_pwl_eval.sv
// Combinational piecewise-linear edge evaluator:
// phi = base + ((slope * t) >>> (DWIDTH-SEG_BITS)), sign-extended to ACC_W.
// Kept free of registers so a multi-lane kernel can instance one per lane.
module kan_pwl_eval #(
  parameter int DWIDTH   = 16,
  parameter int SEG_BITS = 3,
  parameter int ACC_W    = 32
) (
  input  logic        [DWIDTH-SEG_BITS-1:0] t,
  input  logic signed [DWIDTH-1:0]          base,
  input  logic signed [DWIDTH-1:0]          slope,
  output logic signed [ACC_W-1:0]           phi
);
  localparam int TW = DWIDTH - SEG_BITS;
  localparam int PW = DWIDTH + TW + 1;  // full signed product width

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;

  // Full-width signed product, scaled back by the offset width, then biased.
  always_comb begin
    prod   = slope * $signed({1'b0, t});
    scaled = prod >>> TW;
    phi    = ACC_W'(base) + ACC_W'(scaled);
  end

endmodule

// File: rtl/kan_layer_kernel.sv
// One KAN layer pass: pop x_i, evaluate phi_ij for every output j from the
// coefficient RAM, accumulate into acc[j], then push OUT saturated results.
module kan_layer_kernel
  import kan_pkg::*;
(
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [IN_W-1:0]     cfg_in_dim,
  input  logic [OUT_W-1:0]    cfg_out_dim,
  output logic                busy,
  output logic                done,
  input  logic                k_rvalid,
  output logic                k_rready,
  input  logic [DWIDTH-1:0]   k_rdata,
  output logic                k_wvalid,
  input  logic                k_wready,
  output logic [DWIDTH-1:0]   k_wdata,
  output logic                coef_en,
  output logic [ADDR_W-1:0]   coef_addr,
  input  logic [2*DWIDTH-1:0] coef_rdata
);

  state_e                   state_q, state_d;
  logic [IN_W-1:0]          in_q, in_d, i_q, i_d;
  logic [OUT_W-1:0]         out_q, out_d, j_q, j_d;
  logic [DWIDTH-1:0]        x_q, x_d;
  logic                     rd_vld_q, rd_vld_d;   // coef_rdata valid this cycle
  logic [JW-1:0]            rd_j_q, rd_j_d;       // output index of that read
  logic signed [ACC_W-1:0]  acc_q [MAX_OUT];
  logic signed [ACC_W-1:0]  acc_d [MAX_OUT];

  xsplit_t                  xsp;
  logic signed [ACC_W-1:0]  phi;
  logic [RW-1:0]            row;

  assign xsp = split_x(x_q);

  // Edge index i*OUT + j, computed at address width to avoid truncation.
  always_comb begin
    row = RW'(i_q) * RW'(out_q) + RW'(j_q);
  end

  kan_pwl_eval #(
    .DWIDTH   (DWIDTH),
    .SEG_BITS (SEG_BITS),
    .ACC_W    (ACC_W)
  ) u_pwl (
    .t     (xsp.t),
    .base  (coef_rdata[COEF_BASE_LSB +: DWIDTH]),
    .slope (coef_rdata[COEF_SLOPE_LSB +: DWIDTH]),
    .phi   (phi)
  );

  // Control FSM: sequencing, handshakes and coefficient requests.
  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    out_d     = out_q;
    i_d       = i_q;
    j_d       = j_q;
    x_d       = x_q;
    busy      = 1'b0;
    done      = 1'b0;
    k_rready  = 1'b0;
    k_wvalid  = 1'b0;
    k_wdata   = '0;
    coef_en   = 1'b0;
    coef_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d  = cfg_in_dim;
          out_d = cfg_out_dim;
          i_d   = '0;
          j_d   = '0;
          state_d = (cfg_in_dim == '0 || cfg_out_dim == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        k_rready = 1'b1;
        if (k_rvalid) begin
          x_d     = k_rdata;
          j_d     = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        busy      = 1'b1;
        coef_en   = 1'b1;
        coef_addr = {row, xsp.seg};
        j_d       = j_q + 1'b1;
        if (j_q == out_q - OUT_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Last read's data lands this cycle; i must not advance before it.
        busy = 1'b1;
        if (i_q == in_q - IN_W'(1)) begin
          j_d     = '0;
          state_d = S_WRITE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WRITE: begin
        busy     = 1'b1;
        k_wvalid = 1'b1;
        k_wdata  = sat(acc_q[j_q[JW-1:0]] >>> OUT_SHIFT);
        if (k_wready) begin
          j_d = j_q + 1'b1;
          if (j_q == out_q - OUT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulate one RAM word per cycle; the first input overwrites, so no clear pass.
  always_comb begin
    acc_d    = acc_q;
    rd_vld_d = coef_en;
    rd_j_d   = j_q[JW-1:0];
    if (rd_vld_q) begin
      if (i_q == '0) acc_d[rd_j_q] = phi;
      else           acc_d[rd_j_q] = acc_q[rd_j_q] + phi;
    end
  end

  // State, counters and accumulator registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      in_q     <= '0;
      out_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      x_q      <= '0;
      rd_vld_q <= 1'b0;
      rd_j_q   <= '0;
      for (int k = 0; k < MAX_OUT; k++) acc_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      out_q    <= out_d;
      i_q      <= i_d;
      j_q      <= j_d;
      x_q      <= x_d;
      rd_vld_q <= rd_vld_d;
      rd_j_q   <= rd_j_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_kan_layer_kernel.sv
// Bench for kan_layer_kernel: directed and randomized layer passes against an
// arithmetic reference model, with a behavioural coefficient RAM and buffer ports.
module tb_kan_layer_kernel;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [6:0]  cfg_in_dim, cfg_out_dim;
  logic        busy, done;
  logic        k_rvalid, k_rready;
  logic [15:0] k_rdata;
  logic        k_wvalid, k_wready;
  logic [15:0] k_wdata;
  logic        coef_en;
  logic [14:0] coef_addr;
  logic [31:0] coef_rdata;

  kan_layer_kernel dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .cfg_in_dim(cfg_in_dim), .cfg_out_dim(cfg_out_dim),
    .busy(busy), .done(done),
    .k_rvalid(k_rvalid), .k_rready(k_rready), .k_rdata(k_rdata),
    .k_wvalid(k_wvalid), .k_wready(k_wready), .k_wdata(k_wdata),
    .coef_en(coef_en), .coef_addr(coef_addr), .coef_rdata(coef_rdata)
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [32768];
  int          xs_arr [64];
  logic [15:0] xq [$];
  logic [15:0] wq [$];
  int          aq [$];
  int          nreads = 0, ndone = 0, cyc = 0, last_w_cyc = 0, stall_cyc = 0;
  bit          rd_toggle = 0, wstall_en = 0, rv_phase = 0, prev_stall = 0;
  logic [15:0] prev_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Coefficient RAM, one cycle read latency.
  always @(posedge aclk) if (coef_en) coef_rdata <= mem[coef_addr];

  // ---------------- reference model ----------------
  function automatic int seg_of(int x);
    return (x + 32768) / 8192;
  endfunction

  function automatic int model_addr(int i, int j, int nout);
    return (i * nout + j) * 8 + seg_of(xs_arr[i]);
  endfunction

  function automatic logic [15:0] model_y(int nin, int nout, int j);
    int acc;
    acc = 0;
    for (int i = 0; i < nin; i++) begin
      int a, t, b, s;
      longint p;
      a = model_addr(i, j, nout);
      t = (xs_arr[i] + 32768) % 8192;
      b = int'($signed(mem[a][31:16]));
      s = int'($signed(mem[a][15:0]));
      p = longint'(s) * longint'(t);
      acc = acc + b + int'(p >>> 13);  // 32-bit int wraps like the accumulator
    end
    if (acc > 32767)  return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // mode 0: constant c; 1: small random coefficients; 2: full-range random
  task automatic fill_mem(input int mode, input logic [31:0] c);
    for (int a = 0; a < 32768; a++) begin
      if (mode == 0)      mem[a] = c;
      else if (mode == 1) mem[a] = {16'($urandom_range(0, 1023) - 512), 16'($urandom_range(0, 1023) - 512)};
      else                mem[a] = $urandom;
    end
  endtask

  // ---------------- buffer-side drivers and monitor ----------------
  initial begin
    k_rvalid = 1'b0; k_rdata = '0; k_wready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      cyc++;
      rv_phase = rd_toggle ? ~rv_phase : 1'b1;
      k_rvalid = rv_phase && (xq.size() > 0);
      k_rdata  = (xq.size() > 0) ? xq[0] : 16'h0;
      if (wstall_en && wq.size() == 1 && stall_cyc < 3) begin
        k_wready = 1'b0; stall_cyc++;
      end else k_wready = 1'b1;
    end
  end

  initial forever begin
    @(negedge aclk);
    if (k_rvalid && k_rready) begin void'(xq.pop_front()); nreads++; end
    if (k_wvalid && k_wready) begin wq.push_back(k_wdata); last_w_cyc = cyc; end
    if (coef_en) aq.push_back(int'(coef_addr));
    if (done) ndone++;
    chk("port_exclusive", {63'b0, k_rready & (coef_en | k_wvalid)}, 64'd0);
    if (prev_stall) begin
      chk("wvalid_hold", {63'b0, k_wvalid}, 64'd1);
      chk("wdata_stable", {48'b0, k_wdata}, {48'b0, prev_wdata});
    end
    prev_stall = k_wvalid && !k_wready;
    prev_wdata = k_wdata;
  end

  // ---------------- one layer pass with full checking ----------------
  task automatic run_pass(input int nin, input int nout, input bit poke);
    int bound, ndone0, cw, eff_r, eff_w;
    eff_r = (nout > 0) ? nin : 0;
    eff_w = (nin > 0) ? nout : 0;
    xq.delete(); wq.delete(); aq.delete();
    for (int i = 0; i < nin; i++) xq.push_back(16'(xs_arr[i]));
    nreads = 0; stall_cyc = 0; ndone0 = ndone;
    @(posedge aclk); #1;
    cfg_in_dim = 7'(nin); cfg_out_dim = 7'(nout); start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0; cfg_in_dim = 7'($urandom); cfg_out_dim = 7'($urandom);
    chk("busy_after_start", {63'b0, busy}, {63'b0, (eff_r > 0 && eff_w > 0)});
    if (poke) begin
      repeat (3) @(posedge aclk); #1;
      cfg_in_dim = 7'd0; cfg_out_dim = 7'd1; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
    end
    bound = nin * (nout + 2) * 3 + nout * 2 + 60;
    cw = 0;
    @(negedge aclk);
    while (!done && cw < bound) begin @(negedge aclk); cw++; end
    chk("done_seen", {63'b0, done}, 64'd1);
    #1;
    chk("reads", 64'(nreads), 64'(eff_r));
    chk("coef_reads", 64'(aq.size()), 64'((eff_w > 0) ? nin * nout : 0));
    for (int i = 0; i < nin; i++)
      for (int j = 0; j < nout; j++)
        if (i * nout + j < aq.size())
          chk("coef_addr", 64'(aq[i * nout + j]), 64'(model_addr(i, j, nout)));
    chk("writes", 64'(wq.size()), 64'(eff_w));
    for (int j = 0; j < nout && j < wq.size(); j++)
      chk("wdata", {48'b0, wq[j]}, {48'b0, model_y(nin, nout, j)});
    if (eff_r > 0 && eff_w > 0) chk("done_latency", 64'(cyc), 64'(last_w_cyc + 1));
    @(negedge aclk); #1;
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    chk("idle_not_busy", {63'b0, busy}, 64'd0);
    chk("done_count", 64'(ndone), 64'(ndone0 + 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ndone0, cw;
    aresetn = 1'b0; start = 1'b0; cfg_in_dim = '0; cfg_out_dim = '0;
    #3;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_rready", {63'b0, k_rready}, 64'd0);
    chk("rst_wvalid", {63'b0, k_wvalid}, 64'd0);
    chk("rst_coef_en", {63'b0, coef_en}, 64'd0);
    chk("rst_wdata", {48'b0, k_wdata}, 64'd0);
    chk("rst_coef_addr", {49'b0, coef_addr}, 64'd0);
    repeat (2) @(posedge aclk); #1;
    aresetn = 1'b1;

    // Single edge: x=0 -> seg 4, t=0
    fill_mem(0, {16'h0100, 16'h0000});
    xs_arr[0] = 0;
    run_pass(1, 1, 0);
    if (aq.size() > 0) chk("t1_addr", 64'(aq[0]), 64'd4);
    if (wq.size() > 0) chk("t1_y", {48'b0, wq[0]}, 64'h0100);

    // Two inputs, two outputs, constant base
    fill_mem(0, {16'h0080, 16'h0000});
    xs_arr[0] = 16'sh0100; xs_arr[1] = -256;
    run_pass(2, 2, 0);
    if (aq.size() == 4) chk("t2_addr3", 64'(aq[3]), 64'h1B);
    if (wq.size() == 2) chk("t2_y1", {48'b0, wq[1]}, 64'h0100);

    // Slope only
    fill_mem(0, {16'h0000, 16'h0100});
    xs_arr[0] = 16'sh1000;
    run_pass(1, 1, 0);
    if (wq.size() > 0) chk("t3_slope", {48'b0, wq[0]}, 64'h0080);

    // Saturation both ways
    fill_mem(0, {16'h7000, 16'h0000});
    for (int i = 0; i < 4; i++) xs_arr[i] = rnd16();
    run_pass(4, 3, 0);
    if (wq.size() > 0) chk("t4_sat_hi", {48'b0, wq[0]}, 64'h7FFF);
    fill_mem(0, {16'h9000, 16'h0000});
    run_pass(4, 3, 0);
    if (wq.size() > 0) chk("t4_sat_lo", {48'b0, wq[2]}, 64'h8000);

    // Zero dimensions
    run_pass(0, 5, 0);
    run_pass(3, 0, 0);

    // Backpressure on both ports plus an ignored start mid-pass
    fill_mem(1, '0);
    for (int i = 0; i < 6; i++) xs_arr[i] = rnd16();
    rd_toggle = 1; wstall_en = 1;
    run_pass(6, 5, 1);
    rd_toggle = 0; wstall_en = 0;

    // Randomized passes including dimension boundaries
    fill_mem(2, '0);
    for (int i = 0; i < 64; i++) xs_arr[i] = rnd16();
    run_pass(8, 6, 0);
    fill_mem(1, '0);
    run_pass(2, 64, 0);
    run_pass(64, 2, 0);
    run_pass(5, 7, 0);

    // Reset during EVAL aborts with no done pulse
    xq.delete(); wq.delete();
    for (int i = 0; i < 4; i++) xq.push_back(16'(xs_arr[i]));
    @(posedge aclk); #1;
    cfg_in_dim = 7'd4; cfg_out_dim = 7'd8; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cw = 0;
    while (!coef_en && cw < 100) begin @(negedge aclk); cw++; end
    chk("eval_reached", {63'b0, coef_en}, 64'd1);
    ndone0 = ndone;
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_coef_en", {63'b0, coef_en}, 64'd0);
    chk("mid_rst_coef_addr", {49'b0, coef_addr}, 64'd0);
    chk("mid_rst_rready", {63'b0, k_rready}, 64'd0);
    chk("mid_rst_wvalid", {63'b0, k_wvalid}, 64'd0);
    chk("mid_rst_wdata", {48'b0, k_wdata}, 64'd0);
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    chk("no_done_after_abort", 64'(ndone), 64'(ndone0));
    chk("idle_after_abort", {63'b0, busy}, 64'd0);

    // Pass after the abort
    fill_mem(1, '0);
    for (int i = 0; i < 5; i++) xs_arr[i] = rnd16();
    run_pass(5, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
